// File: rtl/audio_fifo_pkg.sv
// Shared defaults and level arithmetic for the audio sample FIFO.
package audio_fifo_pkg;

   localparam int DEF_DATA_WIDTH       = 16;
   localparam int DEF_DEPTH_WIDTH      = 10;
   localparam int DEF_ALMOST_FULL_NUM  = 1020;
   localparam int DEF_ALMOST_EMPTY_NUM = 4;
   localparam int DEF_FWFT             = 0;

   function automatic int next_level(input int level, input logic wr_ok, input logic rd_ok);
      int result;
      result = level;
      if (wr_ok && !rd_ok) begin
         result = level + 1;
      end else if (rd_ok && !wr_ok) begin
         result = level - 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, both on clk.
module audio_fifo_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the read register is cleared; the array keeps whatever it held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/audio_sync_fifo.sv
// Single-clock audio sample FIFO with standard or first-word-fall-through read.
module audio_sync_fifo
   import audio_fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int DEPTH_WIDTH      = DEF_DEPTH_WIDTH,
   parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
   parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM,
   parameter int FWFT             = DEF_FWFT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_empty,
   output logic                  almost_empty,
   output logic [DEPTH_WIDTH:0]  water_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                   DEPTH      = 2 ** DEPTH_WIDTH;
   localparam bit                   FWFT_ON    = (FWFT != 0);
   localparam logic [DEPTH_WIDTH:0] LEVEL_FULL = (DEPTH_WIDTH+1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0] LEVEL_AF   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [DEPTH_WIDTH:0] LEVEL_AE   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

   logic [DEPTH_WIDTH-1:0] wr_ptr;
   logic [DEPTH_WIDTH-1:0] rd_ptr;
   logic [DEPTH_WIDTH:0]   level_next;
   logic [DEPTH_WIDTH:0]   mem_count;
   logic                   wr_ok;
   logic                   rd_ok;
   logic                   fetch;
   logic                   advance;
   logic                   out_valid;
   logic                   out_valid_next;
   logic                   ram_we;
   logic                   ram_re;

   assign wr_ok      = wr_en && !wr_full;
   assign rd_ok      = rd_en && !rd_empty;
   assign level_next = (DEPTH_WIDTH+1)'(next_level(int'(water_level), wr_ok, rd_ok));

   // In FWFT mode the RAM read register doubles as the output register, so
   // it is refilled whenever it is empty or being popped and the array has words.
   assign mem_count      = water_level - {{DEPTH_WIDTH{1'b0}}, out_valid};
   assign fetch          = FWFT_ON && (mem_count != '0) && (!out_valid || rd_ok);
   assign out_valid_next = fetch || (out_valid && !rd_ok);
   assign advance        = FWFT_ON ? fetch : rd_ok;

   assign ram_we = rst_n && !flush && wr_ok;
   assign ram_re = rst_n && !flush && advance;

   audio_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         water_level  <= '0;
         out_valid    <= 1'b0;
         wr_full      <= 1'b0;
         almost_full  <= 1'b0;
         rd_empty     <= 1'b1;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (advance) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         water_level  <= level_next;
         out_valid    <= out_valid_next;
         wr_full      <= (level_next == LEVEL_FULL);
         almost_full  <= (level_next >= LEVEL_AF);
         almost_empty <= (level_next <= LEVEL_AE);
         rd_empty     <= FWFT_ON ? !out_valid_next : (level_next == '0);
         if (wr_en && wr_full) begin
            overflow <= 1'b1;
         end
         if (rd_en && rd_empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_audio_sync_fifo.sv
// Scoreboard bench driving a standard-read and an FWFT instance with shared stimulus.
module tb_audio_sync_fifo;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          full0, full1, af0, af1, empty0, empty1, ae0, ae1, ov0, ov1, un0, un1;
   logic [AW:0]   lvl0, lvl1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: per-instance list of write-edge stamps (storage) and data queues (scoreboard).
   int            stamp0[$];
   int            stamp1[$];
   logic [DW-1:0] exp0[$];
   logic [DW-1:0] exp1[$];
   bit            m_ov0 = 0, m_un0 = 0, m_ov1 = 0, m_un1 = 0;
   bit            pend0 = 0;

   always #5 clk = ~clk;

   audio_sync_fifo #(
      .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(AF),
      .ALMOST_EMPTY_NUM(AE), .FWFT(0)
   ) dut_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(full0), .almost_full(af0), .rd_en(rd_en), .rd_data(rd_data0),
      .rd_empty(empty0), .almost_empty(ae0), .water_level(lvl0),
      .overflow(ov0), .underflow(un0)
   );

   audio_sync_fifo #(
      .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(AF),
      .ALMOST_EMPTY_NUM(AE), .FWFT(1)
   ) dut_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(full1), .almost_full(af1), .rd_en(rd_en), .rd_data(rd_data1),
      .rd_empty(empty1), .almost_empty(ae1), .water_level(lvl1),
      .overflow(ov1), .underflow(un1)
   );

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
      end
   endfunction

   // FWFT head is shown once the edge after its write has passed.
   function automatic bit m_empty1();
      bit e;
      e = 1'b1;
      if (stamp1.size() > 0) begin
         if (stamp1[0] <= cyc - 1) e = 1'b0;
      end
      return e;
   endfunction

   task automatic checkOutput();
      int l0;
      int l1;
      l0 = stamp0.size();
      l1 = stamp1.size();
      check("std_level",      int'(lvl0),   l0);
      check("std_full",       int'(full0),  int'(l0 == DEPTH));
      check("std_empty",      int'(empty0), int'(l0 == 0));
      check("std_afull",      int'(af0),    int'(l0 >= AF));
      check("std_aempty",     int'(ae0),    int'(l0 <= AE));
      check("std_overflow",   int'(ov0),    int'(m_ov0));
      check("std_underflow",  int'(un0),    int'(m_un0));
      check("fwft_level",     int'(lvl1),   l1);
      check("fwft_full",      int'(full1),  int'(l1 == DEPTH));
      check("fwft_empty",     int'(empty1), int'(m_empty1()));
      check("fwft_afull",     int'(af1),    int'(l1 >= AF));
      check("fwft_aempty",    int'(ae1),    int'(l1 <= AE));
      check("fwft_overflow",  int'(ov1),    int'(m_ov1));
      check("fwft_underflow", int'(un1),    int'(m_un1));
   endtask

   task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r,
                                input bit f, input bit rn);
      bit e0, e1, f0, f1, clr;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      flush   = f;
      rst_n   = rn;
      e0  = (stamp0.size() == 0);
      e1  = m_empty1();
      f0  = (stamp0.size() == DEPTH);
      f1  = (stamp1.size() == DEPTH);
      clr = !rn || f;
      @(posedge clk);
      cyc++;
      #1;
      if (clr) begin
         stamp0.delete();
         stamp1.delete();
         exp0.delete();
         exp1.delete();
         m_ov0 = 0; m_un0 = 0; m_ov1 = 0; m_un1 = 0;
      end else begin
         if (w && f0) m_ov0 = 1;
         if (r && e0) m_un0 = 1;
         if (w && f1) m_ov1 = 1;
         if (r && e1) m_un1 = 1;
         if (r && !e0) void'(stamp0.pop_front());
         if (r && !e1) void'(stamp1.pop_front());
         if (w && !f0) begin
            stamp0.push_back(cyc);
            exp0.push_back(d);
         end
         if (w && !f1) begin
            stamp1.push_back(cyc);
            exp1.push_back(d);
         end
      end
      checkOutput();
   endtask

   task automatic doWrite(input logic [DW-1:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic doRead();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic doIdle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic doFlush();
      applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
   endtask

   // Monitor: pops the scoreboard whenever an instance completes a read handshake.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (pend0) begin
         checks++;
         if (exp0.size() == 0) begin
            errors++;
            $display("[TB] FAIL std_rd_order actual=%0h required=no read (scoreboard empty)", rd_data0);
         end else begin
            e = exp0.pop_front();
            checks--;
            check("std_rd_data", int'(rd_data0), int'(e));
         end
      end
      pend0 = rst_n && !flush && rd_en && !empty0;
      if (rst_n && !flush && rd_en && !empty1) begin
         checks++;
         if (exp1.size() == 0) begin
            errors++;
            $display("[TB] FAIL fwft_rd_order actual=%0h required=no read (scoreboard empty)", rd_data1);
         end else begin
            e = exp1.pop_front();
            checks--;
            check("fwft_rd_data", int'(rd_data1), int'(e));
         end
      end
   end

   initial begin
      bit            w, r, f, rn;
      int            wp;
      logic [DW-1:0] d;

      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
      check("rst_rd_data_std",  int'(rd_data0), 0);
      check("rst_rd_data_fwft", int'(rd_data1), 0);
      check("rst_empty_std",    int'(empty0), 1);
      check("rst_aempty_fwft",  int'(ae1), 1);
      doIdle();

      // Fill to full, then one extra write.
      for (int i = 1; i <= 16; i++) doWrite(DW'(i));
      check("fill_full_std",  int'(full0), 1);
      check("fill_level_std", int'(lvl0), 16);
      check("fill_full_fwft", int'(full1), 1);
      check("fill_lvl_fwft",  int'(lvl1), 16);
      doWrite(16'hDEAD);
      check("ovf_flag_std",   int'(ov0), 1);
      check("ovf_level_std",  int'(lvl0), 16);
      check("ovf_flag_fwft",  int'(ov1), 1);

      // Drain to level 10 with overflow still set, then flush.
      for (int i = 0; i < 6; i++) doRead();
      check("lvl10_std", int'(lvl0), 10);
      check("lvl10_ovf", int'(ov0), 1);
      doFlush();
      check("flush_level_std", int'(lvl0), 0);
      check("flush_empty_std", int'(empty0), 1);
      check("flush_ovf_std",   int'(ov0), 0);
      check("flush_lvl_fwft",  int'(lvl1), 0);
      check("flush_ovf_fwft",  int'(ov1), 0);

      // Standard read latency.
      doWrite(16'hA5A5);
      check("std_visible_1cyc", int'(empty0), 0);
      check("fwft_not_yet",     int'(empty1), 1);
      doRead();
      check("std_rd_a5a5",      int'(rd_data0), 'hA5A5);
      check("std_no_underflow", int'(un0), 0);
      check("fwft_shows_a5a5",  int'(rd_data1), 'hA5A5);

      // FWFT fall-through latency.
      doFlush();
      doWrite(16'h1234);
      check("fwft_empty_1cyc", int'(empty1), 1);
      doIdle();
      check("fwft_empty_2cyc", int'(empty1), 0);
      check("fwft_data_2cyc",  int'(rd_data1), 'h1234);

      // Threshold edges.
      doFlush();
      doWrite(16'h0101);
      doWrite(16'h0202);
      check("ae_at2_std",  int'(ae0), 1);
      check("ae_at2_fwft", int'(ae1), 1);
      doWrite(16'h0303);
      check("ae_at3_std",  int'(ae0), 0);
      check("ae_at3_fwft", int'(ae1), 0);
      for (int i = 4; i <= 13; i++) doWrite(DW'(i * 3));
      check("af_at13_std", int'(af0), 0);
      doWrite(16'h0E0E);
      check("af_at14_std",  int'(af0), 1);
      check("af_at14_fwft", int'(af1), 1);

      // Steady streaming at level 8 across several pointer wraps.
      doFlush();
      for (int i = 0; i < 8; i++) doWrite(DW'($urandom));
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b1);
      check("stream_lvl_std",  int'(lvl0), 8);
      check("stream_lvl_fwft", int'(lvl1), 8);

      // Reset mid-operation at level 5.
      doFlush();
      for (int i = 0; i < 6; i++) doWrite(DW'(16'h4000 + i));
      doRead();
      doIdle();
      check("pre_rst_lvl", int'(lvl0), 5);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("mid_rst_lvl_std",   int'(lvl0), 0);
      check("mid_rst_lvl_fwft",  int'(lvl1), 0);
      check("mid_rst_data_std",  int'(rd_data0), 0);
      check("mid_rst_data_fwft", int'(rd_data1), 0);
      check("mid_rst_empty",     int'(empty1), 1);

      // Randomized traffic alternating fill-biased and drain-biased phases.
      for (int i = 0; i < 1200; i++) begin
         wp = ((i / 150) % 2 == 1) ? 30 : 70;
         w  = ($urandom_range(0, 99) < wp);
         r  = ($urandom_range(0, 99) < (100 - wp));
         f  = ($urandom_range(0, 99) == 0);
         rn = ($urandom_range(0, 299) != 0);
         d  = DW'($urandom);
         applyStimulus(w, d, r, f, rn);
      end
      doIdle();
      doIdle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
